sensor_record_ctrl: RTL

- Controller that shares the single dmem port between the processor and a sensor record/playback engine.
- On a save request, the engine streams sensor samples into a ring region of dmem.
- On a load request, it replays the stored samples, oldest first, onto sensor_output.
- The processor always has priority. The engine uses idle dmem cycles, and a small FIFO absorbs stalls.

---
 rtl/sensor_record_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sensor_record_ctrl.sv
// sensor_record_ctrl
//   Shares the single dmem port between the processor and a sensor
//   record/playback engine. While save_signal is high, samples strobed by
//   sample_tick are queued in a small FIFO and written into a ring region of
//   dmem on cycles the processor leaves free. A rising edge of load_signal
//   replays the stored samples, oldest first, onto sensor_output, one read per
//   sample_tick. The processor always owns the port when cpu_req is high.
//
//   dmem is clocked on ~clock, so an address driven during a cycle returns
//   mem_q before the next rising edge, and a write lands mid-cycle.
//
// Ports
//   clock, reset            : master clock, synchronous active-high reset
//   cpu_req/address/data/wren, cpu_q : processor side of the dmem port
//   mem_address/data/wren, mem_q     : dmem side
//   sensor_in, sample_tick  : live sample and its one-cycle strobe
//   save_signal, load_signal: record level / playback start (rising edge)
//   sensor_output           : last replayed sample (registered)
//   busy, overflow          : engine not idle / sticky dropped-sample flag
//   stored_count            : valid records held in the ring
//
// Build option
//   SENSOR_TIMESTAMP_EN : adds input counter[31:0]; every record becomes the
//   pair {sample, counter-at-tick} occupying two consecutive ring words.

module sensor_record_ctrl #(
  parameter logic [11:0] BASE_ADDR  = 12'd2048,
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic [11:0]                cpu_address,
  input  logic [31:0]                cpu_data,
  input  logic                       cpu_wren,
  output logic [31:0]                cpu_q,
  output logic [11:0]                mem_address,
  output logic [31:0]                mem_data,
  output logic                       mem_wren,
  input  logic [31:0]                mem_q,
  input  logic [31:0]                sensor_in,
  input  logic                       sample_tick,
  input  logic                       save_signal,
  input  logic                       load_signal,
`ifdef SENSOR_TIMESTAMP_EN
  input  logic [31:0]                counter,
`endif
  output logic [31:0]                sensor_output,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     stored_count
);

  localparam int PW   = $clog2(DEPTH);      // ring offset width
  localparam int CW   = PW + 1;             // record count width
  localparam int FW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW  = FW + 1;             // FIFO occupancy width
`ifdef SENSOR_TIMESTAMP_EN
  localparam int EW   = 64;                 // {timestamp, sample}
  localparam int SH   = 1;                  // ring words per record = 2
`else
  localparam int EW   = 32;
  localparam int SH   = 0;
`endif
  localparam int CAP  = DEPTH >> SH;        // records the ring can hold

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_PLAY   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic                          save_q, save_d;
  logic                          load_q, load_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                 stored_count_q, stored_count_d;
  logic [CW-1:0]                 rd_idx_q, rd_idx_d;
  logic                          pend_q, pend_d;
  logic [31:0]                   sensor_output_q, sensor_output_d;
  logic                          overflow_q, overflow_d;
  logic [FIFO_DEPTH-1:0][EW-1:0] fifo_mem_q, fifo_mem_d;
  logic [FW-1:0]                 fifo_wp_q, fifo_wp_d;
  logic [FW-1:0]                 fifo_rp_q, fifo_rp_d;
  logic [FCW-1:0]                fifo_cnt_q, fifo_cnt_d;
`ifdef SENSOR_TIMESTAMP_EN
  logic                          half_q, half_d;   // 1: timestamp word next
`endif

  // ---------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------
  logic          save_rise, load_rise;
  logic          fifo_empty, fifo_full;
  logic          eng_wr_req, eng_rd_req;
  logic          wr_fire, rd_fire, last_word;
  logic          push_try, push, pop;
  logic [EW-1:0] fifo_head, fifo_entry;
  logic [31:0]   wr_word;
  logic [PW-1:0] wr_off, rd_off;
  logic [CW-1:0] rd_off_full;

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  always_comb begin
    save_rise  = save_signal & ~save_q;
    load_rise  = load_signal & ~load_q;
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == FCW'(FIFO_DEPTH));
    fifo_head  = fifo_mem_q[fifo_rp_q];

    eng_wr_req = ((state_q == ST_RECORD) || (state_q == ST_DRAIN)) && !fifo_empty;
    eng_rd_req = (state_q == ST_PLAY) && pend_q;
    wr_fire    = eng_wr_req && !cpu_req;
    rd_fire    = eng_rd_req && !cpu_req;

`ifdef SENSOR_TIMESTAMP_EN
    fifo_entry = {counter, sensor_in};
    last_word  = half_q;
    wr_off     = wr_ptr_q + PW'(half_q);
    wr_word    = half_q ? fifo_head[63:32] : fifo_head[31:0];
`else
    fifo_entry = sensor_in;
    last_word  = 1'b1;
    wr_off     = wr_ptr_q;
    wr_word    = fifo_head;
`endif

    // The entry leaves the FIFO only once all of its ring words are written.
    pop      = wr_fire && last_word;
    push_try = (state_q == ST_RECORD) && sample_tick;
    push     = push_try && (!fifo_full || pop);

    // Oldest record sits stored_count records behind wr_ptr; the mod DEPTH
    // comes from truncating to PW bits.
    rd_off_full = CW'(wr_ptr_q) - (stored_count_q << SH) + (rd_idx_q << SH);
    rd_off      = rd_off_full[PW-1:0];
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (save_rise)                                  state_d = ST_RECORD;
        else if (load_rise && (stored_count_q != '0))   state_d = ST_PLAY;
      end
      ST_RECORD: if (!save_signal) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty)   state_d = ST_IDLE;
      ST_PLAY: begin
        // Leave on the edge that captures the final sample.
        if (rd_idx_q >= stored_count_q)                        state_d = ST_IDLE;
        else if (rd_fire && (rd_idx_q + CW'(1) == stored_count_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (port mux and status)
  // ---------------------------------------------------------------------
  always_comb begin
    cpu_q         = mem_q;
    busy          = (state_q != ST_IDLE);
    sensor_output = sensor_output_q;
    overflow      = overflow_q;
    stored_count  = stored_count_q;

    mem_address = cpu_address;
    mem_data    = cpu_data;
    mem_wren    = 1'b0;
    if (cpu_req) begin
      mem_address = cpu_address;
      mem_data    = cpu_data;
      mem_wren    = cpu_wren;
    end else if (eng_wr_req) begin
      mem_address = BASE_ADDR + 12'(wr_off);
      mem_data    = wr_word;
      mem_wren    = 1'b1;
    end else if (eng_rd_req) begin
      mem_address = BASE_ADDR + 12'(rd_off);
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    save_d          = save_signal;
    load_d          = load_signal;
    wr_ptr_d        = wr_ptr_q;
    stored_count_d  = stored_count_q;
    rd_idx_d        = rd_idx_q;
    pend_d          = pend_q;
    sensor_output_d = sensor_output_q;
    overflow_d      = overflow_q;
`ifdef SENSOR_TIMESTAMP_EN
    half_d          = half_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (save_rise) begin
          wr_ptr_d       = '0;
          stored_count_d = '0;
          overflow_d     = 1'b0;
`ifdef SENSOR_TIMESTAMP_EN
          half_d         = 1'b0;
`endif
        end else if (load_rise && (stored_count_q != '0)) begin
          rd_idx_d = '0;
          pend_d   = 1'b0;
        end
      end
      ST_RECORD, ST_DRAIN: begin
        if (push_try && !push) overflow_d = 1'b1;
`ifdef SENSOR_TIMESTAMP_EN
        if (wr_fire) half_d = ~half_q;
`endif
        if (pop) begin
          wr_ptr_d = wr_ptr_q + PW'(1 << SH);
          // Saturate: once full, each new record overwrites the oldest.
          if (stored_count_q != CW'(CAP)) stored_count_d = stored_count_q + CW'(1);
        end
      end
      ST_PLAY: begin
        if (rd_fire) begin
          sensor_output_d = mem_q;
          pend_d          = 1'b0;
          rd_idx_d        = rd_idx_q + CW'(1);
        end else if (sample_tick) begin
          pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointers and storage
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_mem_d[fifo_wp_q] = fifo_entry;
      fifo_wp_d             = fifo_inc(fifo_wp_q);
    end
    if (pop) fifo_rp_d = fifo_inc(fifo_rp_q);
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      save_q          <= 1'b0;
      load_q          <= 1'b0;
      wr_ptr_q        <= '0;
      stored_count_q  <= '0;
      rd_idx_q        <= '0;
      pend_q          <= 1'b0;
      sensor_output_q <= '0;
      overflow_q      <= 1'b0;
      fifo_wp_q       <= '0;
      fifo_rp_q       <= '0;
      fifo_cnt_q      <= '0;
`ifdef SENSOR_TIMESTAMP_EN
      half_q          <= 1'b0;
`endif
    end else begin
      save_q          <= save_d;
      load_q          <= load_d;
      wr_ptr_q        <= wr_ptr_d;
      stored_count_q  <= stored_count_d;
      rd_idx_q        <= rd_idx_d;
      pend_q          <= pend_d;
      sensor_output_q <= sensor_output_d;
      overflow_q      <= overflow_d;
      fifo_wp_q       <= fifo_wp_d;
      fifo_rp_q       <= fifo_rp_d;
      fifo_cnt_q      <= fifo_cnt_d;
`ifdef SENSOR_TIMESTAMP_EN
      half_q          <= half_d;
`endif
    end
  end

  // Entry storage needs no reset: the occupancy count guards every read.
  always_ff @(posedge clock) fifo_mem_q <= fifo_mem_d;

endmodule
